// File: rtl/rcu_pkg.sv
// Shared types and constants for the response capture unit.
package rcu_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    REPORT
  } rcu_state_e;

  // Width of the per-pattern settle counter; holds SETTLE values 0..15.
  localparam int SETTLE_W = 4;

  // Number of patterns in an exhaustive sweep, and therefore the response vector width.
  function automatic int vec_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/rcu_first_fail_enc.sv
// Lowest-set-bit priority encoder over the response/golden difference vector.
// Gives the index of the first failing pattern and whether any pattern failed.
module rcu_first_fail_enc
  import rcu_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [vec_width(IDX_W)-1:0] bits,
  output logic [IDX_W-1:0]            idx,
  output logic                        any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
    idx = '0;
    for (int i = vec_width(IDX_W) - 1; i >= 0; i--) begin
      if (bits[i]) idx = IDX_W'(i);
    end
  end

  assign any = |bits;

endmodule

// File: rtl/response_capture_unit.sv
// Exhaustive stimulus/response engine: sweeps every N_IN-bit pattern into an
// attached DUT, records its one-bit response per pattern, compares the packed
// response vector against a golden vector, and reports over valid/ready.
module response_capture_unit
  import rcu_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                       CK,
  input  logic                       reset,
  input  logic                       start,
  input  logic [vec_width(N_IN)-1:0] golden,
  output logic [N_IN-1:0]            pattern,
  input  logic                       dut_resp,
  output logic                       busy,
  output logic [vec_width(N_IN)-1:0] resp_vec,
  output logic                       mismatch,
  output logic [N_IN-1:0]            first_fail_idx,
  output logic                       resp_valid,
  input  logic                       resp_ready
);

  localparam int                  VEC_W     = vec_width(N_IN);
  localparam logic [N_IN-1:0]     LAST_PAT  = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

  rcu_state_e            state, state_d;
  logic [N_IN-1:0]       pattern_d;
  logic [SETTLE_W-1:0]   settle_cnt, settle_cnt_d;
  logic [VEC_W-1:0]      golden_q, golden_d;
  logic [VEC_W-1:0]      resp_vec_d;
  logic [VEC_W-1:0]      sample_vec;
  logic                  busy_d, resp_valid_d, mismatch_d;
  logic [N_IN-1:0]       first_fail_idx_d;
  logic [N_IN-1:0]       enc_idx;
  logic                  enc_any;

  // The encoder sees the vector including the bit sampled on this edge, so the
  // verdict registered on REPORT entry already covers the last pattern.
  rcu_first_fail_enc #(
    .IDX_W (N_IN)
  ) u_first_fail_enc (
    .bits (sample_vec ^ golden_q),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // Next-state and next-output logic for the sweep controller.
  always_comb begin
    state_d          = state;
    pattern_d        = pattern;
    settle_cnt_d     = settle_cnt;
    golden_d         = golden_q;
    resp_vec_d       = resp_vec;
    busy_d           = busy;
    resp_valid_d     = resp_valid;
    mismatch_d       = mismatch;
    first_fail_idx_d = first_fail_idx;

    sample_vec = resp_vec;
    if (settle_cnt == '0) sample_vec[pattern] = dut_resp;

    unique case (state)
      IDLE: begin
        if (start) begin
          golden_d     = golden;
          resp_vec_d   = '0;
          pattern_d    = '0;
          settle_cnt_d = SETTLE_LD;
          busy_d       = 1'b1;
          state_d      = APPLY;
        end
      end
      APPLY: begin
        if (settle_cnt != '0) begin
          settle_cnt_d = settle_cnt - SETTLE_W'(1);
        end else begin
          resp_vec_d = sample_vec;
          if (pattern == LAST_PAT) begin
            mismatch_d       = enc_any;
            first_fail_idx_d = enc_idx;
            resp_valid_d     = 1'b1;
            state_d          = REPORT;
          end else begin
            pattern_d    = pattern + N_IN'(1);
            settle_cnt_d = SETTLE_LD;
          end
        end
      end
      REPORT: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
          pattern_d    = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any sweep or pending report.
  always_ff @(posedge CK or negedge reset) begin
    // NOTE: the captured golden and response vectors are plain flops, so they are
    // reset with everything else rather than left undefined like a RAM would be.
    if (!reset) begin
      state          <= IDLE;
      pattern        <= '0;
      settle_cnt     <= '0;
      golden_q       <= '0;
      resp_vec       <= '0;
      busy           <= 1'b0;
      resp_valid     <= 1'b0;
      mismatch       <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state          <= state_d;
      pattern        <= pattern_d;
      settle_cnt     <= settle_cnt_d;
      golden_q       <= golden_d;
      resp_vec       <= resp_vec_d;
      busy           <= busy_d;
      resp_valid     <= resp_valid_d;
      mismatch       <= mismatch_d;
      first_fail_idx <= first_fail_idx_d;
    end
  end

endmodule

// File: doc/response_capture_unit.md
# response_capture_unit

Hardware stimulus/response engine that sweeps an N_IN-bit input pattern exhaustively from 0 to 2^N_IN-1 into a combinational/sequential DUT under test. It samples the DUT's single-bit response per pattern and packs the results into a response vector. It then compares that vector against a golden vector and reports the result over a valid/ready handshake. It is the on-chip counterpart of the exhaustive-pattern benches in the trojan-detection flow: it sits beside the DUT, drives its inputs, and collects its output.

## Interface
- N_IN, 4, width of the pattern bus driven to the DUT (1..8)
- SETTLE, 1, idle cycles between applying a pattern and sampling the response (0..15)
- CK  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a sweep; accepted only in IDLE
- golden  input  2^N_IN  expected response vector; captured on the start-accepting edge
- pattern  output  N_IN  stimulus to DUT
- dut_resp  input  1  DUT response
- busy  output  1  high from accept of start until the report handshake completes
- resp_vec  output  2^N_IN  bit i = response sampled for pattern i
- mismatch  output  1  resp_vec != captured golden
- first_fail_idx  output  N_IN  lowest i with resp_vec[i] != golden[i]; 0 if none
- resp_valid  output  1  report available
- resp_ready  input  1  consumer accepts report

## Operation
- States: IDLE, APPLY, REPORT.
- Reset (reset=0, asynchronous): state=IDLE; pattern, resp_vec, mismatch, first_fail_idx, internal index, and settle counter = 0; busy=0; resp_valid=0; captured golden=0.
- IDLE:
  - On the edge where start=1: capture golden, clear resp_vec, pattern=0, settle counter=SETTLE, go to APPLY, busy=1.
- APPLY:
  - If settle counter != 0, decrement it and hold pattern.
  - If counter == 0, write dut_resp into resp_vec[pattern].
  - Then, if pattern == 2^N_IN-1, go to REPORT. Otherwise increment pattern and reload counter=SETTLE.
- REPORT:
  - resp_valid=1, with mismatch and first_fail_idx valid in the same cycle as resp_valid.
  - resp_vec, mismatch, first_fail_idx, and pattern hold stable while resp_valid=1 and resp_ready=0.
  - On resp_valid&&resp_ready: go to IDLE, resp_valid=0, busy=0, pattern=0. resp_vec is retained until the next start.
- start while busy=1 is ignored, including start in the REPORT handshake cycle.
- Pattern never wraps. The sweep ends at the all-ones pattern.
- SETTLE=0 gives one cycle per pattern.

## Timing
- Each pattern is driven for SETTLE+1 cycles. The response is sampled at the final edge of that window.
- resp_valid rises exactly 2^N_IN*(SETTLE+1) cycles after the start-accepting edge. With defaults, that is 32 cycles.
- Minimum start-to-start period is 2^N_IN*(SETTLE+1)+2 cycles, assuming resp_ready is held high.
- All outputs are registered. No combinational path from any input to any output.
- Reset asserted mid-sweep or mid-REPORT aborts immediately. No partial report is produced.

## Structure
- Package rcu_pkg holds:
  - the state enum (IDLE, APPLY, REPORT)
  - the SETTLE counter width localparam (4 bits)
  - the helper function for the vector width, 2^N_IN
- Sub-module rcu_first_fail_enc: parameterised lowest-set-bit priority encoder over resp_vec ^ golden. Outputs the index and an any-set flag, which feeds mismatch.
- Mismatch and index are registered on the entry edge into REPORT.

## Test plan
- Defaults; dut_resp = (pattern==4'b1011); golden=16'h0800 -> resp_vec=16'h0800, mismatch=0, first_fail_idx=0, resp_valid at cycle 32.
- Same DUT, golden=16'h0000 -> mismatch=1, first_fail_idx=11.
- dut_resp = pattern[0]^pattern[3], SETTLE=0, golden=16'h55AA -> resp_vec=16'h55AA, mismatch=0, resp_valid at cycle 16.
- Hold resp_ready=0 for 5 cycles in REPORT -> resp_valid, resp_vec, and mismatch stable. Pulse start during the stall -> ignored. Handshake -> busy=0 next cycle.
- Assert reset while pattern=7 -> pattern=0, busy=0, resp_valid=0, and resp_vec=0 asynchronously. A new start produces a clean full sweep.
- Pulse start at cycle 10 of a sweep -> no restart; sweep completes at the original cycle 32.
